// File: rtl/sw_cond_pkg.sv
// rtl/sw_cond_pkg.sv - shared constants for the switch and step-button input conditioner
package sw_cond_pkg;
    localparam int DEB_CYCLES_DEFAULT   = 1000000;
    localparam int FAST_DIV_BIT_DEFAULT = 24;
    localparam int SLOW_DIV_BIT_DEFAULT = 27;

    localparam int SW_DISP_MODE = 0;
    localparam int SW_STEP_MODE = 1;
    localparam int SW_SLOW_CLK  = 15;
endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchronizer plus stable-count debouncer for one raw input
module debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;
    logic             w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], d_i};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any return to the current level restarts the stability count.
            if (w_s == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_LAST) begin
                r_q    <= w_s;
                r_cnt  <= '0;
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign q_o    = r_q;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/sw_debounce_step.sv
// rtl/sw_debounce_step.sv - debounced switches, edge pulses and CPU advance enable (run or single-step)
module sw_debounce_step
    import sw_cond_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEB_CYCLES   = DEB_CYCLES_DEFAULT,
    parameter int CNT_W        = 20,
    parameter int DIV_W        = 28,
    parameter int FAST_DIV_BIT = FAST_DIV_BIT_DEFAULT,
    parameter int SLOW_DIV_BIT = SLOW_DIV_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             btn_step_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             btn_step_o,
    output logic             cpu_ce_o,
    output logic [31:0]      tick_cnt_o
);

    logic [WIDTH-1:0] w_sw;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             w_btn;
    logic             w_btn_rise;
    logic             w_unused_btn_fall;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sw
            debounce_bit #(
                .DEB_CYCLES(DEB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_sw_deb (
                .clk   (clk),
                .rstn  (rstn),
                .d_i   (sw_i[gi]),
                .q_o   (w_sw[gi]),
                .rise_o(w_rise[gi]),
                .fall_o(w_fall[gi])
            );
        end
    endgenerate

    debounce_bit #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_btn_deb (
        .clk   (clk),
        .rstn  (rstn),
        .d_i   (btn_step_i),
        .q_o   (w_btn),
        .rise_o(w_btn_rise),
        .fall_o(w_unused_btn_fall)
    );

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_fast_hist;
    logic             r_slow_hist;
    logic             w_fast_rise;
    logic             w_slow_rise;
    logic             w_div_tick;
    logic             w_ce_next;
    logic             r_ce;
    logic [31:0]      r_tick;

    // Rises are detected on the edge that produces them, so the enable lands in
    // the cycle the divider reaches the new value and mode is the pre-edge sw_o.
    assign w_div_next  = r_div + DIV_W'(1);
    assign w_fast_rise = w_div_next[FAST_DIV_BIT] & ~r_fast_hist;
    assign w_slow_rise = w_div_next[SLOW_DIV_BIT] & ~r_slow_hist;
    assign w_div_tick  = w_sw[SW_SLOW_CLK] ? w_slow_rise : w_fast_rise;
    assign w_ce_next   = w_sw[SW_STEP_MODE] ? w_btn_rise : w_div_tick;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div       <= '0;
            r_fast_hist <= 1'b0;
            r_slow_hist <= 1'b0;
            r_ce        <= 1'b0;
            r_tick      <= '0;
        end else begin
            r_div       <= w_div_next;
            r_fast_hist <= w_div_next[FAST_DIV_BIT];
            r_slow_hist <= w_div_next[SLOW_DIV_BIT];
            r_ce        <= w_ce_next;
            r_tick      <= r_tick + {31'b0, r_ce};
        end
    end

    assign sw_o       = w_sw;
    assign sw_rise_o  = w_rise;
    assign sw_fall_o  = w_fall;
    assign btn_step_o = w_btn;
    assign cpu_ce_o   = r_ce;
    assign tick_cnt_o = r_tick;

endmodule

// File: tb/tb_sw_debounce_step.sv
// tb/tb_sw_debounce_step.sv - self-checking bench for sw_debounce_step
module tb_sw_debounce_step;
    localparam int NB  = 17;
    localparam int DEB = 4;
    localparam int FB  = 2;
    localparam int SB  = 4;
    localparam int DW  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] sw_i = '0;
    logic        btn_step_i = 1'b0;
    logic [15:0] sw_o, sw_rise_o, sw_fall_o;
    logic        btn_step_o, cpu_ce_o;
    logic [31:0] tick_cnt_o;

    int checks = 0;
    int failures = 0;
    int bk_cyc;

    always #5 clk = ~clk;

    sw_debounce_step #(
        .WIDTH(16), .DEB_CYCLES(DEB), .CNT_W(4), .DIV_W(DW),
        .FAST_DIV_BIT(FB), .SLOW_DIV_BIT(SB)
    ) dut (
        .clk(clk), .rstn(rstn), .sw_i(sw_i), .btn_step_i(btn_step_i),
        .sw_o(sw_o), .sw_rise_o(sw_rise_o), .sw_fall_o(sw_fall_o),
        .btn_step_o(btn_step_o), .cpu_ce_o(cpu_ce_o), .tick_cnt_o(tick_cnt_o)
    );

    typedef struct packed {
        logic [15:0] sw;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        btn;
        logic        ce;
        logic [31:0] tick;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) bk_cyc <= 0;
        else       bk_cyc <= bk_cyc + 1;
    end

    // Reference model: one step per clock, expected outputs queued for the comparator.
    logic [NB-1:0] m_s0, m_s1, m_q, m_rise, m_fall;
    int            m_cnt [NB];
    int            m_div;
    logic          m_ce;
    logic [31:0]   m_tick;

    always @(posedge clk or negedge rstn) begin
        int   sel;
        int   nd;
        logic ce_n;
        logic [NB-1:0] in_v;
        if (!rstn) begin
            m_s0 = '0; m_s1 = '0; m_q = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < NB; i++) m_cnt[i] = 0;
            m_div = 0; m_ce = 1'b0; m_tick = '0;
            sb.delete();
        end else begin
            in_v = {btn_step_i, sw_i};
            nd   = (m_div + 1) % (1 << DW);
            sel  = m_q[15] ? SB : FB;
            if (m_q[1]) ce_n = m_rise[16];
            else        ce_n = (((nd >> sel) & 1) == 1) && (((m_div >> sel) & 1) == 0);
            m_tick = m_tick + {31'b0, m_ce};
            m_ce   = ce_n;
            m_div  = nd;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_s1[i] == m_q[i]) m_cnt[i] = 0;
                else if (m_cnt[i] == DEB - 1) begin
                    m_q[i] = m_s1[i];
                    m_cnt[i] = 0;
                    if (m_s1[i]) m_rise[i] = 1'b1;
                    else         m_fall[i] = 1'b1;
                end else m_cnt[i] = m_cnt[i] + 1;
            end
            m_s1 = m_s0;
            m_s0 = in_v;
        end
        sb.push_back({m_q[15:0], m_rise[15:0], m_fall[15:0], m_q[16], m_ce, m_tick});
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {sw_o, sw_rise_o, sw_fall_o, btn_step_o, cpu_ce_o, tick_cnt_o};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got sw=%h r=%h f=%h b=%b ce=%b tick=%0d exp sw=%h r=%h f=%h b=%b ce=%b tick=%0d",
                         $time, a.sw, a.rise, a.fall, a.btn, a.ce, a.tick,
                         e.sw, e.rise, e.fall, e.btn, e.ce, e.tick);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] sw;
        logic        btn;
        int          hold;
        logic [15:0] exp_sw;
        logic        exp_btn;
    } vec_t;

    vec_t vt [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, cnt, bad, last, expc;
        logic [31:0] t0;

        vt[0] = '{16'hA5A5, 1'b0, 10, 16'hA5A5, 1'b0};
        vt[1] = '{16'h5A5A, 1'b1, 10, 16'h5A5A, 1'b1};
        vt[2] = '{16'h5A5A, 1'b0,  3, 16'h5A5A, 1'b1};
        vt[3] = '{16'hFFFF, 1'b1, 10, 16'hFFFF, 1'b1};
        vt[4] = '{16'h0000, 1'b1,  4, 16'hFFFF, 1'b1};
        vt[5] = '{16'h0000, 1'b0, 10, 16'h0000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {sw_o, sw_rise_o, sw_fall_o, btn_step_o, cpu_ce_o, tick_cnt_o}, '0);
        rstn = 1'b1;

        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (cpu_ce_o) break;
        end
        chk("first_ce_cycle", n, 4);

        for (int v = 0; v < 6; v++) begin
            sw_i = vt[v].sw;
            btn_step_i = vt[v].btn;
            repeat (vt[v].hold) @(negedge clk);
            chk($sformatf("vec%0d_sw", v), sw_o, vt[v].exp_sw);
            chk($sformatf("vec%0d_btn", v), btn_step_o, vt[v].exp_btn);
        end

        // Clean edge on one switch
        sw_i = 16'h0008;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (sw_o[3]) break;
        end
        chk("t1_latency", n, 6);
        chk("t1_rise", sw_rise_o, 16'h0008);
        @(negedge clk);
        chk("t1_rise_clear", sw_rise_o, 16'h0000);

        // Bouncing switch never settles long enough
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            sw_i[5] = (j % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (sw_rise_o[5] || sw_fall_o[5]) bad++;
            end
        end
        sw_i[5] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (sw_rise_o[5] || sw_fall_o[5]) bad++;
        end
        chk("t2_no_pulse", bad, 0);
        chk("t2_level", sw_o[5], 1'b0);

        // Run mode, fast then slow rate
        bad = 0; cnt = 0; last = -1;
        repeat (64) begin
            @(negedge clk);
            if (cpu_ce_o) begin
                if (last >= 0 && bk_cyc - last != 8) bad++;
                last = bk_cyc;
                cnt++;
            end
        end
        chk("t3_fast_interval", bad, 0);
        chk("t3_fast_count", cnt, 8);
        sw_i[15] = 1'b1;
        repeat (8) @(negedge clk);
        bad = 0; cnt = 0;
        repeat (128) begin
            @(negedge clk);
            if (cpu_ce_o) begin
                if (bk_cyc % 32 != 16) bad++;
                cnt++;
            end
        end
        chk("t3_slow_phase", bad, 0);
        chk("t3_slow_count", cnt, 4);

        // Enter step mode exactly when a slow divider rise is taken
        for (n = 0; n < 40 && (bk_cyc % 32) != 10; n++) @(negedge clk);
        chk("t4_align", bk_cyc % 32, 10);
        sw_i = 16'h0002;
        repeat (6) @(negedge clk);
        chk("t4_mode_now_step", sw_o[1], 1'b1);
        chk("t4_coincident_div_fires", cpu_ce_o, 1'b1);
        repeat (6) @(negedge clk);
        t0 = tick_cnt_o;
        cnt = 0;
        btn_step_i = 1'b1; @(negedge clk); cnt += cpu_ce_o;
        btn_step_i = 1'b0; @(negedge clk); cnt += cpu_ce_o;
        btn_step_i = 1'b1;
        repeat (40) begin @(negedge clk); cnt += cpu_ce_o; end
        btn_step_i = 1'b0;
        repeat (12) begin @(negedge clk); cnt += cpu_ce_o; end
        chk("t4_one_step", cnt, 1);
        chk("t4_tick_inc", tick_cnt_o, t0 + 32'd1);
        chk("t4_btn_released", btn_step_o, 1'b0);

        // Mid-operation reset with all switches high
        sw_i = 16'hFFFF;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("t5_async_clear", {sw_o, sw_rise_o, sw_fall_o, btn_step_o, cpu_ce_o, tick_cnt_o}, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (sw_o == 16'hFFFF) break;
        end
        chk("t5_latency", n, 6);
        chk("t5_rise_all", sw_rise_o, 16'hFFFF);
        @(negedge clk);
        chk("t5_rise_clear", sw_rise_o, 16'h0000);

        // Button rise coincident with leaving step mode is ignored
        sw_i = 16'h0002;
        repeat (10) @(negedge clk);
        for (n = 0; n < 10 && (bk_cyc % 8) != 0; n++) @(negedge clk);
        sw_i = 16'h0000;
        btn_step_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_mode_now_run", sw_o[1], 1'b0);
        chk("t6_btn_rose", btn_step_o, 1'b1);
        @(negedge clk);
        chk("t6_btn_ignored", cpu_ce_o, 1'b0);
        bad = 0; cnt = 0; expc = 0;
        repeat (32) begin
            @(negedge clk);
            if (bk_cyc % 8 == 4) expc++;
            if (cpu_ce_o) begin
                cnt++;
                if (bk_cyc % 8 != 4) bad++;
            end
        end
        chk("t6_tick_phase", bad, 0);
        chk("t6_tick_count", cnt, expc);
        btn_step_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
